req_encoder: RTL and testbench
==============================

REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 SHALL have port CLK, input, 1: the single clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port Req, input, 32: per-register write requests, bit n = register n.
REQ-004 SHALL have port Ack, input, 1: consumer accepts the current Wsel/Wen grant.
REQ-005 SHALL have port Wsel, output, 5: encoded index of the granted request.
REQ-006 SHALL have port Wen, output, 1: grant valid, meaning Wsel is meaningful.
REQ-007 SHALL have port Multi, output, 1: more than one Req bit was set when the current grant was taken.
REQ-008 SHALL have port Npend, output, 6: registered popcount of Req, range 0..32.
REQ-009 SHALL be decided as follows: one clock; reset is synchronous and active-high.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and GRANT; the reset state is IDLE.
REQ-011 SHALL, in IDLE with Req != 0, capture the winning index into Wsel, set Wen=1, capture Multi, and enter GRANT on the next edge.
REQ-012 SHALL give a 1-cycle latency: Req sampled at edge k produces Wen=1 after edge k.
REQ-013 SHALL, in IDLE with Req == 0, hold Wen=0 and keep the last Wsel value.
REQ-014 SHALL, in GRANT, hold Wsel, Wen=1 and Multi stable until Ack=1 is sampled, ignoring all Req changes.
REQ-015 SHALL, on Ack=1 in GRANT, clear Wen, update the pointer to (Wsel+1) mod 32, and return to IDLE.
REQ-016 SHALL insert exactly one IDLE cycle between consecutive grants, giving a maximum throughput of one grant per 2 cycles plus Ack wait.
REQ-017 SHALL ignore Ack while in IDLE.
REQ-018 SHALL select the winner as the first set Req bit, searching upward from the pointer and wrapping 31 to 0.
REQ-019 SHALL update Npend every cycle from that cycle's Req, independent of the FSM.
REQ-020 SHALL, when a Req bit drops during GRANT, keep the grant until Ack; an Ack-less abandon is not allowed.
REQ-021 SHALL wrap the pointer from 31 to 0 with no special case.

Reset
REQ-022 SHALL, while RST=1 at an edge, set the state to IDLE, Wen=0, Wsel=0, Multi=0, Npend=0 and pointer=0.
REQ-023 SHALL, on RST asserted in GRANT, drop the grant with no Ack required, giving Wen=0 the next cycle.
REQ-024 SHALL leave all outputs X-free from the first edge with RST=1 onward.

Configuration
REQ-025 SHALL support the macro REQ_ENCODER_ROUND_ROBIN_EN.
REQ-026 SHALL, with the macro defined, use the rotating pointer of REQ-015 and REQ-018.
REQ-027 SHALL, with the macro undefined, hold the pointer constant at 0, so the lowest set index always wins (fixed priority), and synthesize no pointer register.

Verification
REQ-028 SHALL cover: RST=1 for 2 cycles, then Req=0 -> Wen=0, Wsel=0, Npend=0 for 5 cycles.
REQ-029 SHALL cover: Req=32'h0000_0008, Ack=1 on the cycle after Wen rises -> Wen=1 for exactly 1 cycle, Wsel=3, Multi=0, Npend=1.
REQ-030 SHALL cover: Req=32'h8000_0001 held, Ack on every grant, with round-robin enabled -> grant sequence Wsel 0,31,0,31 with Multi=1; with round-robin disabled -> 0,0,0,0.
REQ-031 SHALL cover: a grant to Wsel=5, then Req cleared to 0 and Ack held 0 for 4 cycles -> Wsel=5 and Wen=1 persist; Ack=1 -> Wen=0 the next cycle.
REQ-032 SHALL cover: Req=32'hFFFF_FFFF -> Npend=32; with round-robin enabled, 32 Ack'd grants produce Wsel 0..31 in order, then wrap to 0.
REQ-033 SHALL cover: RST=1 asserted in GRANT with Wsel=12 -> next cycle Wen=0, Wsel=0, and the next grant with Req=32'h0000_1001 is Wsel=0.

Source files
------------

// File: rtl/req_encoder.sv
// Request encoder: grants one set Req bit at a time as an encoded index, held until Ack.
// Define REQ_ENCODER_ROUND_ROBIN_EN for a rotating search start; otherwise lowest index wins.
module req_encoder (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Req,
  input  logic        Ack,
  output logic [4:0]  Wsel,
  output logic        Wen,
  output logic        Multi,
  output logic [5:0]  Npend
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [4:0]  win_idx;
  logic [4:0]  scan_idx;
  logic        found;
  logic [5:0]  req_cnt;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

`ifndef REQ_ENCODER_ROUND_ROBIN_EN
  assign ptr = '0;
`endif

  // Search upward from ptr, wrapping naturally through the 5-bit index.
  always_comb begin
    win_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      scan_idx = ptr + 5'(i);
      if (!found && Req[scan_idx]) begin
        win_idx = scan_idx;
        found   = 1'b1;
      end
    end
  end

  assign req_cnt = popcount(Req);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      Wen   <= 1'b0;
      Wsel  <= '0;
      Multi <= 1'b0;
      Npend <= '0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      Npend <= req_cnt;
      case (state)
        IDLE: begin
          if (found) begin
            Wsel  <= win_idx;
            Wen   <= 1'b1;
            Multi <= (req_cnt > 6'd1);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (Ack) begin
            Wen   <= 1'b0;
            state <= IDLE;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
            ptr   <= Wsel + 5'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder; expectations follow REQ_ENCODER_ROUND_ROBIN_EN when defined.
module tb_req_encoder;

  logic        CLK;
  logic        RST;
  logic [31:0] Req;
  logic        Ack;
  logic [4:0]  Wsel;
  logic        Wen;
  logic        Multi;
  logic [5:0]  Npend;

  int vectors = 0;
  int miscompares = 0;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  req_encoder dut (
    .CLK   (CLK),
    .RST   (RST),
    .Req   (Req),
    .Ack   (Ack),
    .Wsel  (Wsel),
    .Wen   (Wen),
    .Multi (Multi),
    .Npend (Npend)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [4:0] sel, input logic mul);
    check({tag, "_wen"}, 32'(Wen), 32'd1);
    check({tag, "_wsel"}, 32'(Wsel), 32'(sel));
    check({tag, "_multi"}, 32'(Multi), 32'(mul));
  endtask

  initial begin
    logic [4:0] exp_sel;

    // Reset and idle with no requests
    RST = 1'b1; Req = '0; Ack = 1'b0;
    step(); step();
    check("rst_wen", 32'(Wen), 32'd0);
    check("rst_wsel", 32'(Wsel), 32'd0);
    check("rst_multi", 32'(Multi), 32'd0);
    check("rst_npend", 32'(Npend), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_wen", 32'(Wen), 32'd0);
      check("idle_wsel", 32'(Wsel), 32'd0);
      check("idle_npend", 32'(Npend), 32'd0);
    end

    // Single request, one-cycle grant
    Req = 32'h0000_0008;
    step();
    check_grant("single", 5'd3, 1'b0);
    check("single_npend", 32'(Npend), 32'd1);
    Ack = 1'b1; Req = '0;
    step();
    check("single_ack_wen", 32'(Wen), 32'd0);
    check("single_ack_wsel", 32'(Wsel), 32'd3);
    Ack = 1'b0;
    step();
    check("single_after_wen", 32'(Wen), 32'd0);

    // Two requests at the extremes, Ack held
    RST = 1'b1; step(); RST = 1'b0;
    Req = 32'h8000_0001; Ack = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_sel = (RR && (g % 2 == 1)) ? 5'd31 : 5'd0;
      step();
      check_grant("pair", exp_sel, 1'b1);
      check("pair_npend", 32'(Npend), 32'd2);
      step();
      check("pair_gap_wen", 32'(Wen), 32'd0);
    end

    // Grant persists after Req drops, until Ack
    Ack = 1'b0; Req = 32'h0000_0020;
    step();
    check_grant("hold", 5'd5, 1'b0);
    Req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_wen", 32'(Wen), 32'd1);
      check("hold_wsel", 32'(Wsel), 32'd5);
    end
    check("hold_npend", 32'(Npend), 32'd0);
    Ack = 1'b1;
    step();
    check("hold_ack_wen", 32'(Wen), 32'd0);
    Ack = 1'b0;

    // All requests set: full sweep and wrap
    RST = 1'b1; step(); RST = 1'b0;
    Req = 32'hFFFF_FFFF; Ack = 1'b1;
    for (int g = 0; g < 33; g++) begin
      exp_sel = RR ? 5'(g % 32) : 5'd0;
      step();
      check_grant("sweep", exp_sel, 1'b1);
      check("sweep_npend", 32'(Npend), 32'd32);
      step();
      check("sweep_gap_wen", 32'(Wen), 32'd0);
    end

    // Reset during a grant
    Ack = 1'b0; Req = 32'h0000_1000;
    step();
    check_grant("pre_rst", 5'd12, 1'b0);
    RST = 1'b1;
    step();
    check("grant_rst_wen", 32'(Wen), 32'd0);
    check("grant_rst_wsel", 32'(Wsel), 32'd0);
    check("grant_rst_npend", 32'(Npend), 32'd0);
    RST = 1'b0; Req = 32'h0000_1001;
    step();
    check_grant("post_rst", 5'd0, 1'b1);
    check("post_rst_npend", 32'(Npend), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
